// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types, widths and default layer parameters for acc_ctrl
// Contents:
//   HIT_DEF/CH_IN_DEF/CH_OUT_DEF/PIPE_LAT_DEF  default layer geometry (56x56x64, 4-cycle pipe)
//   cw()                                       counter width helper, never below 1 bit
//   COL_W/IC_W/OC_W/DRN_W                      counter widths for the default geometry
//   state_t                                    sequencer state encoding
package acc_pkg;

    localparam int HIT_DEF      = 56;
    localparam int CH_IN_DEF    = 64;
    localparam int CH_OUT_DEF   = 64;
    localparam int PIPE_LAT_DEF = 4;

    // A modulus of 1 still needs a 1-bit register to keep port vectors legal.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = cw(HIT_DEF);
    localparam int IC_W  = cw(CH_IN_DEF);
    localparam int OC_W  = cw(CH_OUT_DEF);
    localparam int DRN_W = cw(PIPE_LAT_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WHT,
        S_STREAM,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/acc_ctrl_loop_cnt.sv
// rtl/acc_ctrl_loop_cnt.sv - modulo-MAX wrap counter with clear, increment and last flag
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   clr_i           force count to 0 (wins over inc_i)
//   inc_i           advance by one, wrapping MAX-1 -> 0
//   cnt_o           current count
//   last_o          count equals MAX-1
module loop_cnt
    import acc_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cw(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/acc_ctrl.sv
// rtl/acc_ctrl.sv - oc x ic layer sequencer: weight fetch, fmap streaming, drain, output unload
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               level start (IDLE only), synchronous abort to IDLE
//   busy, done                 not-IDLE indicator, one-cycle completion pulse
//   wht_req/wht_ack, wht_oc/ic weight fetch handshake and the (oc, ic) being fetched
//   dp_valid, fmap_ic/col      column presented to the datapath
//   acc_clr, acc_last          first / last input channel qualifiers for dp_valid
//   out_valid/out_ready        finished-column unload handshake
//   out_oc, out_col            index of the column being unloaded
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int HIT      = HIT_DEF,
    parameter int CH_IN    = CH_IN_DEF,
    parameter int CH_OUT   = CH_OUT_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  wht_req,
    input  logic                  wht_ack,
    output logic [cw(CH_OUT)-1:0] wht_oc,
    output logic [cw(CH_IN)-1:0]  wht_ic,
    output logic                  dp_valid,
    output logic [cw(CH_IN)-1:0]  fmap_ic,
    output logic [cw(HIT)-1:0]    fmap_col,
    output logic                  acc_clr,
    output logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [cw(CH_OUT)-1:0] out_oc,
    output logic [cw(HIT)-1:0]    out_col
);

    state_t state_q;

    logic [cw(HIT)-1:0]      col_cnt;
    logic [cw(CH_IN)-1:0]    ic_cnt;
    logic [cw(CH_OUT)-1:0]   oc_cnt;
    logic [cw(PIPE_LAT)-1:0] drn_cnt;
    logic col_last, ic_last, oc_last, drn_last;
    logic col_clr, col_inc, ic_clr, ic_inc, oc_clr, oc_inc, drn_clr, drn_inc;
    logic clr_all, out_hs;

    assign out_hs = (state_q == S_OUTPUT) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (abort) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (start)    state_q <= S_LOAD_WHT;
                S_LOAD_WHT: if (wht_ack)  state_q <= S_STREAM;
                S_STREAM:   if (col_last) state_q <= ic_last ? S_DRAIN : S_LOAD_WHT;
                S_DRAIN:    if (drn_last) state_q <= S_OUTPUT;
                S_OUTPUT:   if (out_hs && col_last) state_q <= oc_last ? S_DONE : S_LOAD_WHT;
                S_DONE:     state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Counters are zeroed in IDLE and DONE so every index reads 0 whenever the block is idle.
    always_comb begin
        clr_all = abort || (state_q == S_IDLE) || (state_q == S_DONE);
        col_clr = clr_all || (state_q == S_LOAD_WHT) || (state_q == S_DRAIN);
        col_inc = (state_q == S_STREAM) || out_hs;
        ic_clr  = clr_all || (out_hs && col_last);
        ic_inc  = (state_q == S_STREAM) && col_last && !ic_last;
        oc_clr  = clr_all;
        oc_inc  = out_hs && col_last && !oc_last;
        drn_clr = clr_all || (state_q != S_DRAIN);
        drn_inc = (state_q == S_DRAIN);
    end

    loop_cnt #(.MAX(HIT)) u_col (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(col_clr), .inc_i(col_inc),
        .cnt_o(col_cnt), .last_o(col_last)
    );

    loop_cnt #(.MAX(CH_IN)) u_ic (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(ic_clr), .inc_i(ic_inc),
        .cnt_o(ic_cnt), .last_o(ic_last)
    );

    loop_cnt #(.MAX(CH_OUT)) u_oc (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(oc_clr), .inc_i(oc_inc),
        .cnt_o(oc_cnt), .last_o(oc_last)
    );

    loop_cnt #(.MAX(PIPE_LAT)) u_drn (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(drn_clr), .inc_i(drn_inc),
        .cnt_o(drn_cnt), .last_o(drn_last)
    );

    // Outputs decode only registered state and counters; no input reaches an output directly.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wht_req   = (state_q == S_LOAD_WHT);
    assign dp_valid  = (state_q == S_STREAM);
    assign out_valid = (state_q == S_OUTPUT);
    assign acc_clr   = dp_valid && (ic_cnt == '0);
    assign acc_last  = dp_valid && ic_last;
    assign wht_oc    = oc_cnt;
    assign wht_ic    = ic_cnt;
    assign fmap_ic   = ic_cnt;
    assign fmap_col  = col_cnt;
    assign out_oc    = oc_cnt;
    assign out_col   = col_cnt;

endmodule

// File: tb/tb_acc_ctrl.sv
// tb/tb_acc_ctrl.sv - scoreboard bench for acc_ctrl with HIT=4, CH_IN=2, CH_OUT=2, PIPE_LAT=3
module tb_acc_ctrl;

    localparam int HIT = 4, CH_IN = 2, CH_OUT = 2, PIPE_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, wht_ack = 1'b0, out_ready = 1'b0;
    logic busy, done, wht_req, dp_valid, acc_clr, acc_last, out_valid;
    logic [0:0] wht_oc, wht_ic, fmap_ic, out_oc;
    logic [1:0] fmap_col, out_col;

    acc_ctrl #(.HIT(HIT), .CH_IN(CH_IN), .CH_OUT(CH_OUT), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .wht_req(wht_req), .wht_ack(wht_ack),
        .wht_oc(wht_oc), .wht_ic(wht_ic), .dp_valid(dp_valid),
        .fmap_ic(fmap_ic), .fmap_col(fmap_col), .acc_clr(acc_clr), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_oc(out_oc), .out_col(out_col)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; int c; int d; } ent_t;
    ent_t wq[$];
    ent_t sq[$];
    ent_t oq[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int ack_delay = 0, req_cnt = 0, done_cnt = 0, done_cyc = 0, ov_cycles = 0;
    bit rdy_toggle = 0, tog = 1, ack_n, rdy_n;
    ent_t me;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and responder: drives ack/ready for the current cycle and scores every transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            wht_ack = 0; out_ready = 0; req_cnt = 0; tog = 1;
        end else begin
            ack_n = wht_req && (req_cnt >= ack_delay);
            wht_ack = ack_n;
            if (wht_req) begin
                if (wq.size() == 0) check("wht_unexpected", wq.size(), 1);
                else begin
                    me = wq[0];
                    check("wht_oc", wht_oc, me.a);
                    check("wht_ic", wht_ic, me.b);
                    if (ack_n) void'(wq.pop_front());
                end
                check("req_dp_overlap", dp_valid, 0);
                req_cnt = ack_n ? 0 : req_cnt + 1;
            end else req_cnt = 0;

            if (dp_valid) begin
                if (sq.size() == 0) check("dp_unexpected", sq.size(), 1);
                else begin
                    me = sq.pop_front();
                    check("fmap_ic", fmap_ic, me.a);
                    check("fmap_col", fmap_col, me.b);
                    check("acc_clr", acc_clr, me.c);
                    check("acc_last", acc_last, me.d);
                end
            end else check("flags_without_dp", {acc_clr, acc_last}, 0);

            rdy_n = rdy_toggle ? tog : 1'b1;
            out_ready = rdy_n;
            if (out_valid) begin
                ov_cycles++;
                if (rdy_toggle) tog = ~tog;
            end else tog = 1;
            if (out_valid && rdy_n) begin
                if (oq.size() == 0) check("out_unexpected", oq.size(), 1);
                else begin
                    me = oq.pop_front();
                    check("out_oc", out_oc, me.a);
                    check("out_col", out_col, me.b);
                end
            end

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_full();
        for (int oc = 0; oc < CH_OUT; oc++) begin
            for (int ic = 0; ic < CH_IN; ic++) begin
                wq.push_back('{oc, ic, 0, 0});
                for (int col = 0; col < HIT; col++)
                    sq.push_back('{ic, col, int'(ic == 0), int'(ic == CH_IN - 1)});
            end
            for (int col = 0; col < HIT; col++) oq.push_back('{oc, col, 0, 0});
        end
    endtask

    task automatic do_start(output int t0);
        @(negedge clk);
        start = 1;
        t0 = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_full(input string nm, input int exp_done, input int exp_ov);
        int t0, d0, n;
        d0 = done_cnt;
        ov_cycles = 0;
        push_full();
        do_start(t0);
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_count"}, done_cnt - d0, 1);
        check({nm, "_done_cycle"}, done_cyc - t0, exp_done);
        check({nm, "_out_valid_cycles"}, ov_cycles, exp_ov);
        @(negedge clk);
        check({nm, "_busy_after"}, busy, 0);
        check({nm, "_done_pulse_len"}, done, 0);
        check({nm, "_wht_left"}, wq.size(), 0);
        check({nm, "_dp_left"}, sq.size(), 0);
        check({nm, "_out_left"}, oq.size(), 0);
        wq.delete(); sq.delete(); oq.delete();
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_wht_req"}, wht_req, 0);
        check({nm, "_dp_valid"}, dp_valid, 0);
        check({nm, "_flags"}, {acc_clr, acc_last}, 0);
        check({nm, "_out_valid"}, out_valid, 0);
        check({nm, "_idx"}, {wht_oc, wht_ic, fmap_ic, fmap_col, out_oc, out_col}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, d0, n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        run_full("full", 35, 8);

        ack_delay = 5;
        run_full("ack_delay", 55, 8);
        ack_delay = 0;

        rdy_toggle = 1;
        run_full("ready_toggle", 41, 14);
        rdy_toggle = 0;

        // Abort in STREAM at oc=1, ic=0, col=2.
        d0 = done_cnt;
        push_full();
        do_start(t0);
        n = 0;
        while (!(dp_valid && wht_oc == 1 && fmap_ic == 0 && fmap_col == 2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_point_reached", int'(n < 500), 1);
        abort = 1;
        start = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        check("abort_busy", busy, 0);
        check("abort_dp_valid", dp_valid, 0);
        check("abort_wht_left", wq.size(), 1);
        check("abort_dp_left", sq.size(), 5);
        check("abort_out_left", oq.size(), 4);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_stays_idle", busy, 0);
        wq.delete(); sq.delete(); oq.delete();
        run_full("after_abort", 35, 8);

        // Reset dropped while in OUTPUT.
        push_full();
        do_start(t0);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reset_point_reached", int'(n < 500), 1);
        #2 rst_n = 0;
        #1 check_all_zero("async_reset");
        wq.delete(); sq.delete(); oq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        check_all_zero("reset_release_idle");
        run_full("after_reset", 35, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
